// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer giving two requesters turns on one shared combinational ALU.
// Latency: 2 cycles from the accept cycle to rsp_valid (MUL_LAT+1 for multiply); one op in flight.
// Backpressure: req_ready only in IDLE; the response is held in RESP until rsp_ready of the granted port.
module alu_share_arb #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result
);

  localparam logic [3:0] OP_MUL = 4'b0100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant;
  logic        accept;
  logic        sel;
  logic [3:0]  sel_op;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r, res_r;
  logic        zero_r;
  logic        gnt_r;
  logic        last_grant;
  logic [3:0]  cnt;

  // On a tie the port that did not win last time gets the ALU.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !reset) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept = |grant;
  assign sel    = grant[1];
  assign sel_op = sel ? req_op1 : req_op0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready[gnt_r]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = grant;
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid[gnt_r] = 1'b1;
  end

  // Operand registers feed the ALU directly so its inputs cannot move while an op is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= 4'b0000;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      res_r      <= 32'd0;
      zero_r     <= 1'b0;
      gnt_r      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      if (state == IDLE && accept) begin
        op_r       <= sel_op;
        a_r        <= sel ? req_a1 : req_a0;
        b_r        <= sel ? req_b1 : req_b0;
        gnt_r      <= sel;
        last_grant <= sel;
        cnt        <= (sel_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          res_r  <= alu_result;
          zero_r <= (alu_result == 32'd0);
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign alu_rs1    = a_r;
  assign alu_rs2    = b_r;
  assign alu_opcode = op_r;
  assign rsp_result = res_r;
  assign rsp_zero   = zero_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU on the datapath side.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0 = 4'd0, req_op1 = 4'd0;
  logic [31:0] req_a0 = 32'd0, req_b0 = 32'd0, req_a1 = 32'd0, req_b1 = 32'd0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      4'b0010: alu_result = alu_rs1 + alu_rs2;
      4'b0110: alu_result = alu_rs1 - alu_rs2;
      4'b0100: alu_result = alu_rs1 * alu_rs2;
      4'b0000: alu_result = alu_rs1 & alu_rs2;
      4'b0001: alu_result = alu_rs1 | alu_rs2;
      4'b0011: alu_result = {31'd0, alu_rs1 < alu_rs2};
      4'b0111: alu_result = ~alu_rs1;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; returns cycles from the accept cycle to rsp_valid.
  task automatic wait_rsp(output int n);
    n = 1;
    while (rsp_valid == 2'b00 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    req_valid = 2'b11;
    tick();
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_result, rsp_zero); end
    checks++; if (alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 || alu_opcode !== 4'd0) begin
      errors++; $display("FAIL reset_alu got %h %h %h exp 0 0 0", alu_rs1, alu_rs2, alu_opcode); end
    req_valid = 2'b00;
    reset = 1'b0;
    tick();
    n = 0;
  endtask

  task automatic test_add();
    int n;
    req_op0 = 4'b0010; req_a0 = 32'd5; req_b0 = 32'd7;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++; if (n != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", n); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin errors++; $display("FAIL add_result got %0d/%b exp 12/0", rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_done got %b exp 00", rsp_valid); end
  endtask

  task automatic test_sub_zero();
    int n;
    req_op1 = 4'b0110; req_a1 = 32'h1234; req_b1 = 32'h1234;
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sub_req_ready got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++; if (n != 2) begin errors++; $display("FAIL sub_latency got %0d exp 2", n); end
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL sub_rsp got %b %h %b exp 10 0 1", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL sub_wrong_port_ready got %b exp 10", rsp_valid); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_done got %b exp 00", rsp_valid); end
  endtask

  task automatic test_mul();
    int n;
    req_op0 = 4'b0100; req_a0 = 32'd6; req_b0 = 32'd7;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mul_req_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    req_op0 = 4'b0010; req_a0 = 32'hDEAD; req_b0 = 32'hBEEF;
    n = 1;
    while (rsp_valid == 2'b00 && n < 40) begin
      checks++; if (alu_opcode !== 4'b0100 || alu_rs1 !== 32'd6 || alu_rs2 !== 32'd7) begin
        errors++; $display("FAIL mul_hold got %h %0d %0d exp 4 6 7", alu_opcode, alu_rs1, alu_rs2); end
      tick();
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL mul_latency got %0d exp 4", n); end
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd42 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL mul_rsp got %b %0d %b exp 01 42 0", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_ops();
    int n;
    req_op1 = 4'b0011; req_a1 = 32'd1; req_b1 = 32'hFFFF_FFFF;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++; if (rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin errors++; $display("FAIL slt_unsigned got %0d/%b exp 1/0", rsp_result, rsp_zero); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    req_op0 = 4'b1111; req_a0 = 32'd9; req_b0 = 32'd9;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++; if (n != 2 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL illegal_op got lat %0d %h %b exp 2 0 1", n, rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_round_robin();
    int k;
    logic g [4];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_op0 = 4'b0010; req_a0 = 32'd1;    req_b0 = 32'd2;
    req_op1 = 4'b0001; req_a1 = 32'hF0;   req_b1 = 32'h0F;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      if (req_ready == 2'b11) begin errors++; $display("FAIL rr_both_ready got 11 exp one-hot"); end
      if (req_ready != 2'b00) begin g[k] = req_ready[1]; k++; end
      if (rsp_valid == 2'b01) begin
        checks++; if (rsp_result !== 32'd3) begin errors++; $display("FAIL rr_p0_result got %h exp 3", rsp_result); end
      end
      if (rsp_valid == 2'b10) begin
        checks++; if (rsp_result !== 32'hFF) begin errors++; $display("FAIL rr_p1_result got %h exp ff", rsp_result); end
      end
      tick();
    end
    req_valid = 2'b00;
    checks++; if (k != 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", k); end
    for (int i = 0; i < k; i++) begin
      checks++; if (g[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_grant_%0d got port %0d exp port %0d", i, g[i], i % 2); end
    end
    repeat (4) tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    int n;
    req_op1 = 4'b0000; req_a1 = 32'hFF00_FF00; req_b1 = 32'h0FF0_0FF0;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    req_op0 = 4'b0111; req_a0 = 32'd0; req_b0 = 32'd0;
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h0F00_0F00 || rsp_zero !== 1'b0 || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold_%0d got %b %h %b rdy %b exp 10 0f000f00 0 rdy 00", c, rsp_valid, rsp_result, rsp_zero, req_ready); end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release got %b rdy %b exp 00 rdy 01", rsp_valid, req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_mul();
    req_op0 = 4'b0100; req_a0 = 32'd3; req_b0 = 32'd5;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rst_mid_valid got %b rdy %b exp 00 00", rsp_valid, req_ready); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 || alu_opcode !== 4'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %h %b %h %h %h exp all 0", rsp_result, rsp_zero, alu_rs1, alu_rs2, alu_opcode); end
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_tie got %b exp 01", req_ready); end
    req_valid = 2'b00;
    repeat (5) tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_no_rsp got %b exp 00", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_mul();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer for the single shared 32-bit ALU datapath. Two requesters (port 0: EX-stage integer path; port 1: branch/compare helper) present operands and a 4-bit ALU opcode. The block grants one request at a time round-robin, holds the ALU inputs stable for the operation's latency, and returns a registered result and zero flag through a valid/ready response handshake. It sits between the pipeline requesters and the combinational ALU.

## Interface
- MUL_LAT, 3: cycles the ALU inputs are held for opcode 4'b0100 (multiply); legal range 1..15.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port request accept; a request transfers on an edge where valid[i] & ready[i].
- req_op0, req_op1  in  4 each  ALU opcode per port.
- req_a0, req_b0, req_a1, req_b1  in  32 each  operands per port.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_result  out  32  result for the port whose rsp_valid is high.
- rsp_zero  out  1  1 when rsp_result == 0.
- alu_rs1, alu_rs2  out  32 each  operands to ALU.
- alu_opcode  out  4  opcode to ALU.
- alu_result  in  32  combinational result from ALU.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset -> IDLE.
- Grant (combinational, IDLE only): if exactly one req_valid bit set, grant it; if both set, grant the port opposite to last_grant. last_grant resets to 1, so port 0 wins the first tie.
- req_ready[i] = (state == IDLE) & grant[i]; never both high; 0 outside IDLE.
- On accept: capture op/a/b of granted port into op_r/a_r/b_r, store gnt_r, update last_grant = gnt_r, load cnt = (op == 4'b0100) ? MUL_LAT-1 : 0, go EXEC.
- alu_rs1/alu_rs2/alu_opcode are always driven from a_r/b_r/op_r (stable through EXEC and RESP).
- EXEC: if cnt == 0, capture alu_result into res_r, set zero_r = (alu_result == 0), go RESP; else cnt decrements.
- RESP: rsp_valid[gnt_r] = 1, other bit 0. On rsp_ready[gnt_r] go IDLE. rsp_ready on the non-granted port is ignored.
- Supported opcodes: 0010 add, 0110 sub, 0100 mul, 0000 and, 0001 or, 0011 slt (unsigned), 0111 not. Any other opcode is accepted and sequenced with latency 1; result is whatever the ALU returns (0).
- Zero flag is computed by this block for every opcode; the ALU zero output is not used.
- Results are 32 bits; multiply returns the low 32 bits of the product; add/sub wrap modulo 2^32.

## Timing
- Reset values: req_ready = 0 during reset cycle, rsp_valid = 2'b00, rsp_result = 0, rsp_zero = 0, alu_rs1 = alu_rs2 = 0, alu_opcode = 4'b0000, cnt = 0, last_grant = 1.
- Latency (accept edge to first cycle rsp_valid high): 2 cycles for non-mul, MUL_LAT+1 cycles for mul.
- Throughput: one operation in flight; minimum 3 cycles per op with rsp_ready held high (IDLE, EXEC, RESP).
- Response backpressure: RESP held indefinitely; rsp_result/rsp_zero stable while rsp_valid high.
- A request arriving during EXEC/RESP waits (req_ready = 0); requester must hold valid and operands stable.
- Reset mid-operation: abort, drop pending response, return to IDLE next cycle, last_grant = 1.

## Test plan
- Single add: port 0 op 0010, a=5, b=7 -> req_ready[0] same cycle; 2 cycles later rsp_valid=2'b01, rsp_result=12, rsp_zero=0.
- Sub to zero: port 1 op 0110, a=b=0x1234 -> rsp_valid=2'b10, rsp_result=0, rsp_zero=1.
- Multiply latency, MUL_LAT=3: port 0 op 0100, a=6, b=7 -> rsp_valid first high 4 cycles after accept, result 42; alu_opcode and operands unchanged for all 3 EXEC cycles.
- Round-robin tie: both valid continuously, rsp_ready=2'b11 -> grants alternate 0,1,0,1; no port accepted twice in a row.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_result held; req_ready stays 0; response completes on rsp_ready high, then IDLE.
- Reset mid-mul: assert reset during second EXEC cycle -> next cycle rsp_valid=0, outputs at reset values; subsequent tie grants port 0.
